// File: rtl/rd_resp_arbiter.sv
// Round-robin merge of N_SRC read-response sources, each with a 1-entry holding register, onto one tagged channel.
// Latency: 2 cycles from src_ack to dst_ack when uncontended; throughput 1 response/cycle.
// Backpressure: none; an ack hitting an occupied, ungranted entry is dropped and ovf flagged. RD_ARB_CNT_EN adds grant counters.
module rd_resp_arbiter #(
    parameter int   DWIDTH = 32,
    parameter int   N_SRC  = 4,
    parameter int   CNT_W  = 16,
    localparam int  SRC_W  = $clog2(N_SRC)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [N_SRC*DWIDTH-1:0] src_rdata,
    input  logic [N_SRC-1:0]        src_resp,
    input  logic [N_SRC-1:0]        src_ack,
    output logic [DWIDTH-1:0]       dst_rdata,
    output logic                    dst_resp,
    output logic                    dst_ack,
    output logic [SRC_W-1:0]        dst_src,
    output logic [N_SRC-1:0]        pend,
    output logic [N_SRC-1:0]        ovf,
    input  logic                    ovf_clr,
    input  logic [SRC_W-1:0]        cnt_sel,
    output logic [CNT_W-1:0]        cnt_val
);

    logic [DWIDTH-1:0] hold_dat [N_SRC];
    logic [N_SRC-1:0]  hold_rsp;
    logic [N_SRC-1:0]  pend_q;
    logic [N_SRC-1:0]  ovf_q;
    logic [SRC_W-1:0]  last_grant;

    logic              gnt_vld;
    logic [SRC_W-1:0]  gnt_idx;
    logic [N_SRC-1:0]  gnt_oh;
    logic [N_SRC-1:0]  cap;
    logic [N_SRC-1:0]  ovf_set;

    // Search starts just after the last winner, wrapping modulo N_SRC.
    always_comb begin
        int         idx;
        logic [SRC_W-1:0] sel;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        sel     = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = (int'(last_grant) + k) % N_SRC;
            sel = SRC_W'(idx);
            if (!gnt_vld && pend_q[sel]) begin
                gnt_vld = 1'b1;
                gnt_idx = sel;
            end
        end
    end

    assign gnt_oh  = gnt_vld ? (N_SRC'(1) << gnt_idx) : '0;
    // A granted entry frees up this same edge, so it may be reloaded without loss.
    assign cap     = src_ack & (~pend_q | gnt_oh);
    assign ovf_set = src_ack & pend_q & ~gnt_oh;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_SRC; i++) hold_dat[i] <= '0;
            hold_rsp   <= '0;
            pend_q     <= '0;
            ovf_q      <= '0;
            last_grant <= SRC_W'(N_SRC - 1);
            dst_rdata  <= '0;
            dst_resp   <= 1'b0;
            dst_ack    <= 1'b0;
            dst_src    <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (cap[i]) begin
                    hold_dat[i] <= src_rdata[i*DWIDTH +: DWIDTH];
                    hold_rsp[i] <= src_resp[i];
                end
            end
            pend_q  <= cap | (pend_q & ~gnt_oh);
            ovf_q   <= (ovf_clr ? '0 : ovf_q) | ovf_set;
            dst_ack <= gnt_vld;
            if (gnt_vld) begin
                dst_rdata  <= hold_dat[gnt_idx];
                dst_resp   <= hold_rsp[gnt_idx];
                dst_src    <= gnt_idx;
                last_grant <= gnt_idx;
            end
        end
    end

    assign pend = pend_q;
    assign ovf  = ovf_q;

`ifdef RD_ARB_CNT_EN
    logic [CNT_W-1:0] cnt_q [N_SRC];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
        end else if (ovf_clr) begin
            for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
        end else if (gnt_vld && (cnt_q[gnt_idx] != {CNT_W{1'b1}})) begin
            cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 1'b1;
        end
    end

    always_comb begin
        cnt_val = '0;
        if (int'(cnt_sel) < N_SRC) cnt_val = cnt_q[cnt_sel];
    end
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_val        = '0;
`endif

endmodule

// File: tb/tb_rd_resp_arbiter.sv
// Random and directed stimulus against a queue-free round-robin reference model of rd_resp_arbiter.
module tb_rd_resp_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [N*DW-1:0] src_rdata;
    logic [N-1:0]    src_resp, src_ack;
    logic [DW-1:0]   dst_rdata;
    logic            dst_resp, dst_ack;
    logic [1:0]      dst_src;
    logic [N-1:0]    pend, ovf;
    logic            ovf_clr;
    logic [1:0]      cnt_sel;
    logic [15:0]     cnt_val;

    rd_resp_arbiter #(.DWIDTH(DW), .N_SRC(N), .CNT_W(16)) dut (
        .aclk(aclk), .aresetn(aresetn), .src_rdata(src_rdata), .src_resp(src_resp),
        .src_ack(src_ack), .dst_rdata(dst_rdata), .dst_resp(dst_resp), .dst_ack(dst_ack),
        .dst_src(dst_src), .pend(pend), .ovf(ovf), .ovf_clr(ovf_clr), .cnt_sel(cnt_sel),
        .cnt_val(cnt_val)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one slot per source plus a rotating priority pointer.
    int          m_last;
    bit          m_pend [N];
    logic [31:0] m_dat  [N];
    bit          m_rsp  [N];
    bit          m_ovf  [N];
    int          m_cnt  [N];
    bit          e_ack;
    logic [31:0] e_rdata;
    bit          e_resp;
    int          e_src;

    function automatic void model_reset();
        m_last = N - 1;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_dat[i] = 0; m_rsp[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
        end
        e_ack = 0; e_rdata = 0; e_resp = 0; e_src = 0;
    endfunction

    function automatic void model_edge();
        int g = -1;
        for (int k = 1; k <= N; k++) begin
            int s = (m_last + k) % N;
            if (g < 0 && m_pend[s]) g = s;
        end
        e_ack = (g >= 0);
        if (g >= 0) begin
            e_rdata   = m_dat[g];
            e_resp    = m_rsp[g];
            e_src     = g;
            m_last    = g;
            m_pend[g] = 0;
            if (m_cnt[g] < 65535) m_cnt[g]++;
        end
        if (ovf_clr) begin
            for (int i = 0; i < N; i++) begin m_ovf[i] = 0; m_cnt[i] = 0; end
        end
        for (int i = 0; i < N; i++) begin
            if (src_ack[i]) begin
                if (m_pend[i]) m_ovf[i] = 1;
                else begin
                    m_pend[i] = 1;
                    m_dat[i]  = src_rdata[i*DW +: DW];
                    m_rsp[i]  = src_resp[i];
                end
            end
        end
    endfunction

    task automatic compare();
        logic [N-1:0] pv, ov;
        logic [15:0]  ec;
        for (int i = 0; i < N; i++) begin pv[i] = m_pend[i]; ov[i] = m_ovf[i]; end
`ifdef RD_ARB_CNT_EN
        ec = 16'(m_cnt[cnt_sel]);
`else
        ec = 16'd0;
`endif
        chk("dst_ack", dst_ack, e_ack);
        chk("dst_rdata", dst_rdata, e_rdata);
        chk("dst_resp", dst_resp, e_resp);
        chk("dst_src", dst_src, e_src);
        chk("pend", pend, pv);
        chk("ovf", ovf, ov);
        chk("cnt_val", cnt_val, ec);
    endtask

    task automatic step(input logic [N-1:0] ack, input logic [N*DW-1:0] dat,
                        input logic [N-1:0] rsp, input logic clr);
        src_ack = ack; src_rdata = dat; src_resp = rsp; ovf_clr = clr;
        cnt_sel = 2'($urandom_range(0, 3));
        @(posedge aclk);
        model_edge();
        #1;
        compare();
        src_ack = '0; ovf_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        #2 aresetn = 1'b0;
        model_reset();
        #1 compare();
        #2 aresetn = 1'b1;
    endtask

    logic [N*DW-1:0] d;
    bit seen_a1, seen_a2;

    initial begin
        aresetn = 1'b0; src_rdata = '0; src_resp = '0; src_ack = '0; ovf_clr = 1'b0; cnt_sel = '0;
        model_reset();
        #12;
        compare();
        chk("rst_dst_ack", dst_ack, 0);
        chk("rst_pend", pend, 0);
        aresetn = 1'b1;

        // single response from source 2
        d = '0; d[2*DW +: DW] = 32'hDEADBEEF;
        step(4'b0100, d, '0, 1'b0);
        chk("single_t1_ack", dst_ack, 0);
        idle(1);
        chk("single_ack", dst_ack, 1);
        chk("single_dat", dst_rdata, 32'hDEADBEEF);
        chk("single_src", dst_src, 2);
        idle(1);
        chk("single_ack_once", dst_ack, 0);
        chk("single_pend", pend[2], 0);

        // all-source burst after reset
        do_reset();
        for (int i = 0; i < N; i++) d[i*DW +: DW] = 32'h10 + i;
        step(4'hF, d, '0, 1'b0);
        for (int i = 0; i < N; i++) begin
            idle(1);
            chk("burst_ack", dst_ack, 1);
            chk("burst_src", dst_src, i);
            chk("burst_dat", dst_rdata, 32'h10 + i);
        end
        idle(1);

        // rotation: last grant 1, sources 0 and 3 pending
        d = '0; d[1*DW +: DW] = 32'h21;
        step(4'b0010, d, '0, 1'b0);
        d = '0; d[0 +: DW] = 32'h30; d[3*DW +: DW] = 32'h33;
        step(4'b1001, d, '0, 1'b0);
        chk("rot_src1", dst_src, 1);
        idle(1);
        chk("rot_first", dst_src, 3);
        idle(1);
        chk("rot_second", dst_src, 0);
        idle(2);

        // overflow on source 1
        do_reset();
        d[0 +: DW] = 32'hB0; d[1*DW +: DW] = 32'hA1; d[2*DW +: DW] = 32'hB2; d[3*DW +: DW] = 32'hB3;
        step(4'hF, d, '0, 1'b0);
        d[0 +: DW] = 32'hB4; d[1*DW +: DW] = 32'hA2;
        step(4'b0011, d, '0, 1'b0);
        chk("ovf1_set", ovf[1], 1);
        seen_a1 = 0; seen_a2 = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (dst_ack && dst_src == 2'd1 && dst_rdata == 32'hA1) seen_a1 = 1;
            if (dst_ack && dst_rdata == 32'hA2) seen_a2 = 1;
        end
        chk("ovf_a1_out", seen_a1, 1);
        chk("ovf_a2_drop", seen_a2, 0);
        step('0, '0, '0, 1'b1);
        chk("ovf_clr", ovf, 0);

        // back-to-back on source 0
        d = '0; d[0 +: DW] = 32'hC0;
        step(4'b0001, d, '0, 1'b0);
        d[0 +: DW] = 32'hC1;
        step(4'b0001, d, '0, 1'b0);
        chk("b2b_ack0", dst_ack, 1);
        chk("b2b_dat0", dst_rdata, 32'hC0);
        idle(1);
        chk("b2b_ack1", dst_ack, 1);
        chk("b2b_dat1", dst_rdata, 32'hC1);
        chk("b2b_ovf", ovf, 0);
        idle(2);

        // reset mid-drain
        for (int i = 0; i < N; i++) d[i*DW +: DW] = 32'h50 + i;
        step(4'hF, d, 4'b0101, 1'b0);
        idle(1);
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_ack", dst_ack, 0);
        chk("mid_rst_pend", pend, 0);
        model_reset();
        compare();
        #2 aresetn = 1'b1;
        idle(4);

        // random traffic
        for (int n = 0; n < 500; n++) begin
            logic [N-1:0] a;
            for (int i = 0; i < N; i++) a[i] = ($urandom_range(0, 2) == 0);
            step(a, {$urandom, $urandom, $urandom, $urandom}, N'($urandom),
                 ($urandom_range(0, 15) == 0));
        end
        idle(N + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
